// File: rtl/vmem_pkg.sv
// vmem_pkg: default geometry and FSM state type shared by the vector memory sequencer
package vmem_pkg;
   localparam int LANES_DEF  = 16;
   localparam int ELEM_W_DEF = 16;
   localparam int STRIDE_DEF = 2;
   typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} vmem_state_t;
endpackage

// File: rtl/vmem_lane_ctr.sv
// vmem_lane_ctr: element index counter with terminal-count flag; wraps to 0 after the last lane
module vmem_lane_ctr #(
   parameter int LANES = 16,
   parameter int IW    = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          clear,
   output logic [IW-1:0] idx,
   output logic          last
);
   logic [IW-1:0] idx_q, idx_d;
   assign last = idx_q == IW'(LANES - 1);
   assign idx  = idx_q;
   // clear has priority; a beat on the last lane wraps so the next transfer starts clean
   always_comb idx_d = clear ? '0 : (enable ? (last ? '0 : idx_q + 1'b1) : idx_q);
   // index register
   always_ff @(posedge clk or negedge reset)
      if (!reset) idx_q <= '0;
      else        idx_q <= idx_d;
endmodule

// File: rtl/vmem_sequencer.sv
// vmem_sequencer: serialises vector loads/stores into per-element memory beats.
// Optional macro VMEM_SEQ_ALIGN_CHK_EN adds an err output that rejects odd base addresses.
module vmem_sequencer
   import vmem_pkg::*;
#(
   parameter int LANES  = LANES_DEF,
   parameter int ELEM_W = ELEM_W_DEF,
   parameter int STRIDE = STRIDE_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    vload_req,
   input  logic                    vstore_req,
   input  logic [31:0]             base_addr,
   input  logic [LANES*ELEM_W-1:0] store_vec,
   input  logic [ELEM_W-1:0]       mem_rdata,
   input  logic                    mem_ready,
   output logic [31:0]             mem_addr,
   output logic                    mem_en,
   output logic                    mem_we,
   output logic [ELEM_W-1:0]       mem_wdata,
   output logic [LANES*ELEM_W-1:0] load_vec,
   output logic                    busy,
   output logic                    done
`ifdef VMEM_SEQ_ALIGN_CHK_EN
   ,
   output logic                    err
`endif
);
   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int VW = LANES * ELEM_W;
   vmem_state_t   state_q, state_d;
   logic [31:0]   base_q, base_d;
   logic [VW-1:0] vec_q, vec_d, load_q, load_d;
   logic [IW-1:0] idx;
   logic          last, xfer, beat, accept, misalign;
`ifdef VMEM_SEQ_ALIGN_CHK_EN
   logic          err_q, err_d;
   assign misalign = base_addr[0];
   assign err      = err_q;
`else
   assign misalign = 1'b0;
`endif
   assign xfer = (state_q == LOAD) || (state_q == STORE);
   assign beat = xfer && mem_ready;
   vmem_lane_ctr #(.LANES(LANES), .IW(IW)) u_ctr (
      .clk    (clk),
      .reset  (reset),
      .enable (beat),
      .clear  (accept),
      .idx    (idx),
      .last   (last)
   );
   // next state: accept only in IDLE (load wins), finish after the last lane's beat
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: if ((vload_req || vstore_req) && !misalign) begin
            accept  = 1'b1;
            state_d = vload_req ? LOAD : STORE;
         end
         LOAD, STORE: if (mem_ready && last) state_d = DONE;
         DONE: state_d = IDLE;
      endcase
   end
   // capture request operands and assemble load lanes as beats complete
   always_comb begin
      base_d = accept ? base_addr : base_q;
      vec_d  = (accept && !vload_req) ? store_vec : vec_q;
      load_d = load_q;
      if (state_q == LOAD && mem_ready) load_d[int'(idx)*ELEM_W +: ELEM_W] = mem_rdata;
   end
`ifdef VMEM_SEQ_ALIGN_CHK_EN
   // one-cycle error pulse for a rejected misaligned request
   always_comb err_d = (state_q == IDLE) && (vload_req || vstore_req) && misalign;
`endif
   // state and datapath registers
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q <= IDLE;
         base_q  <= '0;
         vec_q   <= '0;
         load_q  <= '0;
`ifdef VMEM_SEQ_ALIGN_CHK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         vec_q   <= vec_d;
         load_q  <= load_d;
`ifdef VMEM_SEQ_ALIGN_CHK_EN
         err_q   <= err_d;
`endif
      end
   // memory-side outputs are quiet outside LOAD/STORE
   always_comb begin
      mem_en    = xfer;
      mem_we    = state_q == STORE;
      mem_addr  = xfer ? base_q + 32'(idx) * 32'(STRIDE) : '0;
      mem_wdata = xfer ? vec_q[int'(idx)*ELEM_W +: ELEM_W] : '0;
      busy      = xfer;
      done      = state_q == DONE;
      load_vec  = load_q;
   end
endmodule

// File: tb/tb_vmem_sequencer.sv
// tb_vmem_sequencer: randomized self-checking bench against a beat-level transfer model
module tb_vmem_sequencer;
   localparam int L = 16, W = 16, S = 2, LW = L * W;
   logic clk = 0, reset = 0, vload_req = 0, vstore_req = 0, mem_ready = 0;
   logic [31:0] base_addr = '0;
   logic [LW-1:0] store_vec = '0;
   logic [W-1:0] mem_rdata = '0;
   logic [31:0] mem_addr;
   logic mem_en, mem_we, busy, done;
   logic [W-1:0] mem_wdata;
   logic [LW-1:0] load_vec;
`ifdef VMEM_SEQ_ALIGN_CHK_EN
   logic err;
`endif
   int vectors = 0, miscompares = 0;
   logic [LW-1:0] exp_lv = '0;

   always #5 clk = ~clk;

   vmem_sequencer dut (
      .clk(clk), .reset(reset), .vload_req(vload_req), .vstore_req(vstore_req),
      .base_addr(base_addr), .store_vec(store_vec), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .load_vec(load_vec), .busy(busy), .done(done)
`ifdef VMEM_SEQ_ALIGN_CHK_EN
      , .err(err)
`endif
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic test_reset;
      reset = 0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({busy, done, mem_en, mem_we} !== 4'b0 || mem_addr !== 0 || mem_wdata !== 0 || load_vec !== 0) begin
         miscompares++;
         $display("FAIL reset_state: busy=%b done=%b en=%b we=%b addr=%h wdata=%h lv_nz=%b exp all 0",
                  busy, done, mem_en, mem_we, mem_addr, mem_wdata, |load_vec);
      end
      reset = 1;
      @(negedge clk);
      vectors++;
      if ({busy, done, mem_en} !== 3'b0) begin
         miscompares++;
         $display("FAIL idle_after_reset: busy=%b done=%b en=%b exp 000", busy, done, mem_en);
      end
   endtask

   // mode: 0 ready always high, 1 ready high on even cycles, 2 random ready
   task automatic xfer(input bit ld, input bit both, input bit noise, input logic [31:0] base,
                       input logic [LW-1:0] sv, input int mode, input bit fixed, output int lat);
      int k, n;
      bit rdy;
      logic [W-1:0] d;
      vload_req = ld | both;
      vstore_req = ~ld | both;
      base_addr = base;
      store_vec = sv;
      @(negedge clk);
      vload_req = 0;
      vstore_req = 0;
      base_addr = $urandom;
      store_vec = {8{$urandom}};
      k = 0;
      n = 1;
      while (k < L && n < 200) begin
         vectors++;
         if ({mem_en, busy, done, mem_we} !== {3'b110, ~ld}) begin
            miscompares++;
            $display("FAIL beat_ctl k=%0d: en=%b busy=%b done=%b we=%b exp 1 1 0 %b", k, mem_en, busy, done, mem_we, ~ld);
         end
         vectors++;
         if (mem_addr !== base + 32'(S * k)) begin
            miscompares++;
            $display("FAIL beat_addr k=%0d: got %h exp %h", k, mem_addr, base + 32'(S * k));
         end
         if (!ld) begin
            vectors++;
            if (mem_wdata !== sv[k*W +: W]) begin
               miscompares++;
               $display("FAIL beat_wdata k=%0d: got %h exp %h", k, mem_wdata, sv[k*W +: W]);
            end
         end
         rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 0) : 1'($urandom_range(0, 1));
         d = fixed ? W'(32'h1000 + k) : W'($urandom);
         mem_ready = rdy;
         mem_rdata = d;
         if (noise) begin
            vload_req = 1'($urandom_range(0, 1));
            vstore_req = 1'($urandom_range(0, 1));
            base_addr = $urandom;
         end
         if (rdy) begin
            if (ld) exp_lv[k*W +: W] = d;
            k++;
         end
         @(negedge clk);
         n++;
      end
      mem_ready = 0;
      vload_req = 0;
      vstore_req = 0;
      lat = n;
      if (k < L) begin
         miscompares++;
         $display("FAIL xfer_timeout: beats=%0d exp %0d", k, L);
      end
      vectors++;
      if ({done, busy, mem_en, mem_we} !== 4'b1000 || mem_wdata !== 0) begin
         miscompares++;
         $display("FAIL done_pulse: done=%b busy=%b en=%b we=%b wdata=%h exp 1000 0", done, busy, mem_en, mem_we, mem_wdata);
      end
      @(negedge clk);
      vectors++;
      if ({done, busy, mem_en} !== 3'b0) begin
         miscompares++;
         $display("FAIL done_len: done=%b busy=%b en=%b exp 000", done, busy, mem_en);
      end
      vectors++;
      if (load_vec !== exp_lv) begin
         miscompares++;
         $display("FAIL load_vec: got %h exp %h", load_vec, exp_lv);
      end
   endtask

   task automatic test_load;
      int lat;
      logic [LW-1:0] ref_v;
      xfer(1, 0, 0, 32'h100, '0, 0, 1, lat);
      vectors++;
      if (lat !== 17) begin
         miscompares++;
         $display("FAIL load_latency: got %0d exp 17", lat);
      end
      for (int k = 0; k < L; k++) ref_v[k*W +: W] = W'(32'h1000 + k);
      vectors++;
      if (load_vec !== ref_v) begin
         miscompares++;
         $display("FAIL load_lanes: got %h exp %h", load_vec, ref_v);
      end
   endtask

   task automatic test_store;
      int lat;
      logic [LW-1:0] sv;
      for (int k = 0; k < L; k++) sv[k*W +: W] = W'(k);
      xfer(0, 0, 0, 32'h200, sv, 0, 0, lat);
      vectors++;
      if (lat !== 17) begin
         miscompares++;
         $display("FAIL store_latency: got %0d exp 17", lat);
      end
   endtask

   task automatic test_stall;
      int lat;
      xfer(1, 0, 0, 32'h140, '0, 1, 1, lat);
      vectors++;
      if (lat !== 33) begin
         miscompares++;
         $display("FAIL stall_latency: got %0d exp 33", lat);
      end
   endtask

   task automatic test_priority_ignore;
      int lat;
      xfer(1, 1, 1, 32'h300, {8{$urandom}}, 2, 0, lat);
      xfer(0, 0, 1, 32'h400, {8{$urandom}}, 2, 0, lat);
   endtask

   task automatic test_reset_mid;
      vload_req = 1;
      base_addr = 32'h100;
      @(negedge clk);
      vload_req = 0;
      mem_ready = 1;
      mem_rdata = 16'hBEEF;
      repeat (7) @(negedge clk);
      vectors++;
      if (mem_addr !== 32'h10E) begin
         miscompares++;
         $display("FAIL mid_addr: got %h exp 0000010e", mem_addr);
      end
      #2 reset = 0;
      #1;
      vectors++;
      if ({busy, done, mem_en, mem_we} !== 4'b0 || mem_addr !== 0 || mem_wdata !== 0 || load_vec !== 0) begin
         miscompares++;
         $display("FAIL mid_reset: busy=%b done=%b en=%b we=%b addr=%h wdata=%h lv_nz=%b exp all 0",
                  busy, done, mem_en, mem_we, mem_addr, mem_wdata, |load_vec);
      end
      exp_lv = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (done !== 0 || busy !== 0) begin
            miscompares++;
            $display("FAIL mid_no_done: done=%b busy=%b exp 0 0", done, busy);
         end
      end
      mem_ready = 0;
      reset = 1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({done, busy} !== 2'b0) begin
         miscompares++;
         $display("FAIL mid_after: done=%b busy=%b exp 0 0", done, busy);
      end
   endtask

   task automatic test_align;
`ifdef VMEM_SEQ_ALIGN_CHK_EN
      for (int i = 0; i < 2; i++) begin
         vload_req = (i == 0);
         vstore_req = (i == 1);
         base_addr = 32'h101;
         @(negedge clk);
         vload_req = 0;
         vstore_req = 0;
         vectors++;
         if (err !== 1 || busy !== 0 || mem_en !== 0) begin
            miscompares++;
            $display("FAIL align_err: err=%b busy=%b en=%b exp 1 0 0", err, busy, mem_en);
         end
         @(negedge clk);
         vectors++;
         if (err !== 0 || busy !== 0) begin
            miscompares++;
            $display("FAIL align_pulse: err=%b busy=%b exp 0 0", err, busy);
         end
      end
`else
      int lat;
      xfer(1, 0, 0, 32'h101, '0, 0, 0, lat);
      xfer(0, 0, 0, 32'h101, {8{$urandom}}, 2, 0, lat);
`endif
   endtask

   task automatic test_random;
      int lat;
      logic [31:0] b;
      for (int i = 0; i < 8; i++) begin
         b = (i == 0) ? 32'hFFFF_FFF0 : $urandom;
`ifdef VMEM_SEQ_ALIGN_CHK_EN
         b = b & ~32'd1;
`endif
         xfer(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), b, {8{$urandom}}, 2, 0, lat);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      test_reset;
      test_load;
      test_store;
      test_stall;
      test_priority_ignore;
      test_reset_mid;
      test_align;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
